div: RTL and testbench
======================

Name: div

Overview:
- Iterative 32-bit integer divider for the LA32R execute stage. Executes DIV.W, MOD.W, DIV.WU and MOD.WU.
- It is the inverse-operation counterpart of the Booth/Wallace multiplier and sits beside it in the EX stage.
- Uses radix-2 restoring division on operand magnitudes, followed by a sign-fix step.
- Fixed latency; valid/ready handshake on both the input and the output side; flushable.

Parameters:
- W, 32, operand and result width.
- CNT_W, 5, iteration counter width; equals clog2(W).

Ports:
- mul_clk  input  1  clock.
- reset  input  1  synchronous, active-low.
- div_valid  input  1  operands valid.
- div_ready  output  1  divider can accept operands; high only in IDLE.
- div_signed  input  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- x  input  W  dividend.
- y  input  W  divisor.
- div_cancel  input  1  pipeline flush; abort current operation.
- res_valid  output  1  quotient/remainder valid.
- res_ready  input  1  consumer accepts result.
- quotient  output  W  quotient.
- remainder  output  W  remainder.

Behaviour:
- Reset: reset is synchronous, active-low, clocked by mul_clk. Reset low at an edge gives state=IDLE, res_valid=0, quotient=0, remainder=0, cnt=0. Reset mid-operation discards the operation; no result is ever produced for it.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - div_ready=1.
  - Accept at edge T when div_valid=1 and div_cancel=0.
  - On accept, latch sign flags: xs = div_signed & x[31], ys = div_signed & y[31].
  - Latch magnitudes |x| and |y| (unsigned view), latch the raw x, and set a dz flag = (y==0).
  - Clear the partial remainder, cnt=0, go to CALC.
- CALC: one restoring step per edge, performed by div_step.
  - r' = {r, q[W-1]}, then q shifted left.
  - If r' >= |y|: r = r' - |y| and the new q bit is 1; otherwise r = r' and the new q bit is 0.
  - The partial remainder is W+1 bits wide.
  - 32 steps, at edges T+1..T+32. cnt increments each step; wrap from 31 to 0 goes to SIGN.
- SIGN: at edge T+33, register the outputs and go to DONE.
  - If dz=1: quotient = 32'hFFFFFFFF and remainder = raw x, in both signed and unsigned modes.
  - Otherwise: quotient = (xs^ys) ? -q : q, and remainder = xs ? -r : r. The remainder sign follows the dividend; the quotient truncates toward zero.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) falls out naturally: quotient = 0x80000000, remainder = 0.
- DONE: res_valid=1; quotient and remainder are held stable.
  - On the edge where res_ready=1: go to IDLE, res_valid=0.
  - While res_ready=0: hold indefinitely.
- Latency: 33 edges from the accept edge to res_valid high. Constant; independent of operand values, including divide-by-zero.
- res_valid and res_ready are both registered/level-based; no combinational path from div_valid to res_valid.
- div_cancel:
  - In any state, at the next edge go to IDLE with res_valid=0; quotient and remainder keep their old values.
  - In IDLE, cancel together with div_valid means the operands are not accepted.
  - Cancel in DONE together with res_ready: cancel wins (the result counts as not consumed, which is harmless).
- Back-to-back operation: the earliest re-accept is the edge after the DONE handshake, because div_ready is only high in IDLE. Throughput is 1 operation per 35 cycles minimum.
- Inputs x, y and div_signed are sampled only at the accept edge and may change afterwards.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE, CALC, SIGN, DONE);
  - constants DIV_W=32, DIV_CNT_W=5 and DIV_ITER=32;
  - DIV_DZ_QUOT = 32'hFFFFFFFF.
- Sub-module div_step is combinational. Inputs: partial remainder (W+1 bits), dividend-shift MSB, divisor magnitude. Outputs: next remainder and the quotient bit. It is instantiated once in CALC.
- Sign fix and the FSM stay in div.

Test Plan:
- Unsigned 7/2: div_signed=0, x=7, y=2 -> res_valid exactly 33 edges after accept; quotient=3, remainder=1.
- Signed mixed signs:
  - x=0xFFFFFFF9 (-7), y=2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - x=7, y=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- Corner cases:
  - Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - Unsigned 0xFFFFFFFF/0x10 -> quotient=0x0FFFFFFF, remainder=0xF.
- Divide by zero: x=0x12345678, y=0, both modes -> quotient=0xFFFFFFFF, remainder=0x12345678, same 33-edge latency.
- Backpressure and back-to-back:
  - Hold res_ready=0 for 10 cycles after res_valid -> outputs stable, div_ready=0.
  - Raise res_ready -> the next op is accepted the cycle after, with correct results.
- Cancel and reset:
  - Assert div_cancel at CALC cnt=15 -> IDLE next edge, no res_valid, next op correct.
  - Drive reset low at cnt=20 -> res_valid=0, outputs zero, div_ready=1 after release.
  - div_valid and div_cancel together in IDLE -> not accepted.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the LA32R iterative integer divider.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;
  localparam int DIV_ITER  = 32;

  localparam logic [DIV_W-1:0] DIV_DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Two's-complement negate when neg is set; used for both magnitude and sign fix.
  function automatic logic [DIV_W-1:0] div_neg_if(input logic neg, input logic [DIV_W-1:0] v);
    logic [DIV_W-1:0] res;
    if (neg) begin
      res = ~v + 32'd1;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W:0]   rem_i,
  input  logic         msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         qbit_o
);

  logic [W+1:0] shifted_s;
  logic [W+1:0] diff_s;

  // One extra guard bit makes the borrow of the trial subtraction the compare result.
  always_comb begin
    shifted_s = {rem_i, msb_i};
    diff_s    = shifted_s - {2'b00, dvs_i};
    qbit_o    = ~diff_s[W+1];
    if (qbit_o) begin
      rem_o = diff_s[W:0];
    end else begin
      rem_o = shifted_s[W:0];
    end
  end

endmodule

// File: rtl/div.sv
// Iterative 32-bit divider (DIV.W/MOD.W/DIV.WU/MOD.WU): restoring division on magnitudes,
// then a sign-fix cycle; fixed 33-edge latency with valid/ready on both sides.
module div
  import div_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic         mul_clk,
  input  logic         reset,
  input  logic         div_valid,
  output logic         div_ready,
  input  logic         div_signed,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         div_cancel,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xs_q, xs_d, ys_q, ys_d, dz_q, dz_d;
  logic [W-1:0]     xraw_q, xraw_d, ymag_q, ymag_d, q_q, q_d;
  logic [W:0]       r_q, r_d;
  logic [W-1:0]     quot_q, quot_d, rem_q, rem_d;
  logic             res_valid_q, res_valid_d;

  logic [W:0]       step_rem_s;
  logic             step_qbit_s;
  logic             xs_s, ys_s;

  div_step #(.W(W)) u_step (
    .rem_i  (r_q),
    .msb_i  (q_q[W-1]),
    .dvs_i  (ymag_q),
    .rem_o  (step_rem_s),
    .qbit_o (step_qbit_s)
  );

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    dz_d        = dz_q;
    xraw_d      = xraw_q;
    ymag_d      = ymag_q;
    q_d         = q_q;
    r_d         = r_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    res_valid_d = res_valid_q;
    xs_s        = div_signed & x[W-1];
    ys_s        = div_signed & y[W-1];

    case (state_q)
      IDLE: begin
        if (div_valid && !div_cancel) begin
          xs_d    = xs_s;
          ys_d    = ys_s;
          dz_d    = (y == {W{1'b0}});
          xraw_d  = x;
          q_d     = div_neg_if(xs_s, x);
          ymag_d  = div_neg_if(ys_s, y);
          r_d     = {(W+1){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        r_d   = step_rem_s;
        q_d   = {q_q[W-2:0], step_qbit_s};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SIGN;
        end else begin
          state_d = CALC;
        end
      end
      SIGN: begin
        // Divide-by-zero reports all-ones and the raw dividend regardless of mode.
        if (dz_q) begin
          quot_d = DIV_DZ_QUOT;
          rem_d  = xraw_q;
        end else begin
          quot_d = div_neg_if(xs_q ^ ys_q, q_q);
          rem_d  = div_neg_if(xs_q, r_q[W-1:0]);
        end
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    if (div_cancel) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
      quot_d      = quot_q;
      rem_d       = rem_q;
    end else begin
      res_valid_d = res_valid_d;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge mul_clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      dz_q        <= 1'b0;
      xraw_q      <= {W{1'b0}};
      ymag_q      <= {W{1'b0}};
      q_q         <= {W{1'b0}};
      r_q         <= {(W+1){1'b0}};
      quot_q      <= {W{1'b0}};
      rem_q       <= {W{1'b0}};
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      dz_q        <= dz_d;
      xraw_q      <= xraw_d;
      ymag_q      <= ymag_d;
      q_q         <= q_d;
      r_q         <= r_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign div_ready = (state_q == IDLE);
  assign res_valid = res_valid_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for div: latency, signed/unsigned results, corners,
// backpressure, cancel and reset.
module tb_div;

  logic        mul_clk = 1'b0;
  logic        reset = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic [31:0] x = 32'd0;
  logic [31:0] y = 32'd0;
  logic        div_cancel = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;

  always #5 mul_clk = ~mul_clk;

  div dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .div_cancel (div_cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mul_clk);
    #1;
  endtask

  // Wait (bounded) for div_ready, present operands, and step past the accept edge.
  task automatic start_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!div_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, {31'd0, div_ready}, 32'd1);
    div_signed = s;
    x          = a;
    y          = b;
    div_valid  = 1'b1;
    tick();
    div_valid  = 1'b0;
    x          = $urandom;
    y          = $urandom;
    div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!res_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd33);
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'd0, res_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er);
    start_op(tag, s, a, b);
    wait_result(tag);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] hold_q, hold_r;
    int seen;

    tick();
    tick();
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_quot", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    chk("rst_ready", {31'd0, div_ready}, 32'd1);
    reset = 1'b1;
    tick();

    run_op("u7_2",    1'b0, 32'd7,          32'd2,          32'd3,          32'd1);
    run_op("sn7_2",   1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF);
    run_op("s7_n2",   1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1);
    run_op("s_ovf",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0);
    run_op("dz_u",    1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678);
    run_op("dz_s",    1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678);

    // Backpressure on an unsigned corner case, then back-to-back accept.
    start_op("bp", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010);
    wait_result("bp");
    chk("bp_quot", quotient, 32'h0FFF_FFFF);
    chk("bp_rem", remainder, 32'h0000_000F);
    hold_q = quotient;
    hold_r = remainder;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_vld", {31'd0, res_valid}, 32'd1);
      chk("bp_hold_quot", quotient, hold_q);
      chk("bp_hold_rem", remainder, hold_r);
      chk("bp_hold_rdy", {31'd0, div_ready}, 32'd0);
    end
    res_ready  = 1'b1;
    div_valid  = 1'b1;
    div_signed = 1'b1;
    x          = 32'hFFFF_FF9C;
    y          = 32'hFFFF_FFF9;
    tick();
    res_ready = 1'b0;
    chk("b2b_vld_drop", {31'd0, res_valid}, 32'd0);
    chk("b2b_ready", {31'd0, div_ready}, 32'd1);
    tick();
    div_valid = 1'b0;
    x         = $urandom;
    y         = $urandom;
    wait_result("b2b");
    chk("b2b_quot", quotient, 32'd14);
    chk("b2b_rem", remainder, 32'hFFFF_FFFE);
    consume("b2b");

    // Cancel at cnt=15: back to IDLE, no result, outputs keep the previous result.
    start_op("cn", 1'b0, 32'd500, 32'd3);
    repeat (15) tick();
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    chk("cn_ready", {31'd0, div_ready}, 32'd1);
    chk("cn_vld", {31'd0, res_valid}, 32'd0);
    chk("cn_quot_kept", quotient, 32'd14);
    chk("cn_rem_kept", remainder, 32'hFFFF_FFFE);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) seen++;
    end
    chk("cn_no_result", 32'(seen), 32'd0);
    run_op("cn_next", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6);

    // Valid together with cancel in IDLE must not start an operation.
    div_valid  = 1'b1;
    div_cancel = 1'b1;
    x          = 32'd9;
    y          = 32'd3;
    tick();
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    chk("vc_ready", {31'd0, div_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid || !div_ready) seen++;
    end
    chk("vc_not_accepted", 32'(seen), 32'd0);

    // Reset at cnt=20 discards the operation and clears the outputs.
    start_op("rs", 1'b1, 32'hFFFF_FF9C, 32'd3);
    repeat (20) tick();
    reset = 1'b0;
    tick();
    chk("rs_vld", {31'd0, res_valid}, 32'd0);
    chk("rs_quot", quotient, 32'd0);
    chk("rs_rem", remainder, 32'd0);
    reset = 1'b1;
    chk("rs_ready", {31'd0, div_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (res_valid) seen++;
    end
    chk("rs_no_result", 32'(seen), 32'd0);
    run_op("rs_next", 1'b1, 32'hFFFF_FF9C, 32'd3, 32'hFFFF_FFDF, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
